// File: rtl/cop0_pkg.sv
// cop0_pkg: CP0 register numbers, SR/Cause bit positions and ExcCode constants
package cop0_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam int SR_IE       = 0;
  localparam int SR_EL       = 1;
  localparam int SR_UM       = 4;
  localparam int SR_IM_LO    = 8;
  localparam int SR_IM_HI    = 15;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_LO = 8;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_EX_LO = 2;
  localparam int CAUSE_EX_HI = 6;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8
  } exc_code_e;
endpackage

// File: rtl/cop0_regfile_param_if.sv
// cop0_regfile_param_if: pipeline <-> CP0 bus; COP0_BADVADDR_EN adds iBadVAddr
interface cop0_regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int IRQ_W  = 8
);
  logic [4:0]        iReadRegister;
  logic [DATA_W-1:0] oReadData;
  logic [4:0]        iWriteRegister;
  logic [DATA_W-1:0] iWriteData;
  logic              iRegWrite;
  logic              iExcOccurred;
  logic [4:0]        iExcCode;
  logic [DATA_W-1:0] iExcPC;
  logic              iBranchDelay;
  logic              iEret;
  logic [DATA_W-1:0] oEretTarget;
  logic [IRQ_W-2:0]  iPendingInterrupt;
  logic [IRQ_W-1:0]  oInterruptMask;
  logic              oIntRequest;
  logic              oUserMode;
  logic              oExcLevel;
  logic [4:0]        iRegDispSelect;
  logic [DATA_W-1:0] oRegDisp;
`ifdef COP0_BADVADDR_EN
  logic [DATA_W-1:0] iBadVAddr;
`endif
  modport master (
    output iReadRegister, iWriteRegister, iWriteData, iRegWrite, iExcOccurred, iExcCode,
           iExcPC, iBranchDelay, iEret, iPendingInterrupt, iRegDispSelect,
`ifdef COP0_BADVADDR_EN
    output iBadVAddr,
`endif
    input  oReadData, oEretTarget, oInterruptMask, oIntRequest, oUserMode, oExcLevel, oRegDisp
  );
  modport slave (
    input  iReadRegister, iWriteRegister, iWriteData, iRegWrite, iExcOccurred, iExcCode,
           iExcPC, iBranchDelay, iEret, iPendingInterrupt, iRegDispSelect,
`ifdef COP0_BADVADDR_EN
    input  iBadVAddr,
`endif
    output oReadData, oEretTarget, oInterruptMask, oIntRequest, oUserMode, oExcLevel, oRegDisp
  );
endinterface

// File: rtl/cop0_timer.sv
// cop0_timer: prescaled Count, Compare and the latched compare-match interrupt
module cop0_timer #(
  parameter int DATA_W    = 32,
  parameter int COUNT_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_we_i,
  input  logic              compare_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] compare_o,
  output logic              timer_irq_o
);
  localparam int PW = COUNT_DIV > 1 ? $clog2(COUNT_DIV) : 1;
  logic [PW-1:0]     pre_q, pre_d;
  logic [DATA_W-1:0] count_q, count_d, compare_q, compare_d;
  logic              pend_q, pend_d, tick;
  assign tick = pre_q == PW'(COUNT_DIV - 1);
  // next state: a Count write overrides the tick, a Compare write overrides a match
  always_comb begin
    pre_d     = (count_we_i || tick) ? '0 : pre_q + 1'b1;
    count_d   = count_we_i ? wdata_i : tick ? count_q + 1'b1 : count_q;
    compare_d = compare_we_i ? wdata_i : compare_q;
    pend_d    = compare_we_i ? 1'b0 : (tick && count_q == compare_q) ? 1'b1 : pend_q;
  end
  // timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_irq_o = pend_q;
endmodule

// File: rtl/cop0_regfile_param.sv
// cop0_regfile_param: CP0 register file (Count/Compare/SR/Cause/EPC); COP0_BADVADDR_EN adds BadVAddr
module cop0_regfile_param
  import cop0_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              IRQ_W     = 8,
  parameter int              COUNT_DIV = 2,
  parameter logic [DATA_W-1:0] SR_RESET  = 32'h00000511
) (
  input logic iCLK,
  input logic iCLR,
  cop0_regfile_param_if.slave bus
);
  logic [DATA_W-1:0] sr_q, sr_d, epc_q, epc_d, count, compare, bad_val, cause_val;
  logic              bd_q, bd_d, timer_irq, wr;
  logic [4:0]        exc_q, exc_d;
  logic [1:0]        sw_q, sw_d;
  logic [7:0]        ip8;
  logic [DATA_W-1:0] cp0_map [32];
  assign wr = bus.iRegWrite && !bus.iExcOccurred && !bus.iEret;
  cop0_timer #(.DATA_W(DATA_W), .COUNT_DIV(COUNT_DIV)) u_timer (
    .clk         (iCLK),
    .rst         (iCLR),
    .count_we_i  (wr && bus.iWriteRegister == REG_COUNT),
    .compare_we_i(wr && bus.iWriteRegister == REG_COMPARE),
    .wdata_i     (bus.iWriteData),
    .count_o     (count),
    .compare_o   (compare),
    .timer_irq_o (timer_irq)
  );
  // exception beats eret beats mtc0; nested exceptions keep EPC and BD
  always_comb begin
    sr_d  = sr_q;
    epc_d = epc_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    sw_d  = sw_q;
    if (bus.iExcOccurred) begin
      sr_d[SR_EL] = 1'b1;
      sr_d[SR_UM] = 1'b0;
      exc_d       = bus.iExcCode;
      epc_d       = sr_q[SR_EL] ? epc_q : bus.iExcPC;
      bd_d        = sr_q[SR_EL] ? bd_q : bus.iBranchDelay;
    end else if (bus.iEret) begin
      sr_d[SR_EL] = 1'b0;
      sr_d[SR_UM] = 1'b1;
    end else if (bus.iRegWrite) begin
      sr_d  = bus.iWriteRegister == REG_SR ? bus.iWriteData : sr_q;
      epc_d = bus.iWriteRegister == REG_EPC ? bus.iWriteData : epc_q;
      sw_d  = bus.iWriteRegister == REG_CAUSE ? bus.iWriteData[9:8] : sw_q;
    end
  end
  // SR, EPC and the writable Cause fields
  always_ff @(posedge iCLK) begin
    if (iCLR) begin
      sr_q  <= SR_RESET;
      epc_q <= '0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      sw_q  <= '0;
    end else begin
      sr_q  <= sr_d;
      epc_q <= epc_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      sw_q  <= sw_d;
    end
  end
`ifdef COP0_BADVADDR_EN
  logic [DATA_W-1:0] badvaddr_q;
  // capture the faulting address on first-level address errors only
  always_ff @(posedge iCLK) begin
    if (iCLR) badvaddr_q <= '0;
    else if (bus.iExcOccurred && !sr_q[SR_EL] && (bus.iExcCode == EXC_ADEL || bus.iExcCode == EXC_ADES))
      badvaddr_q <= bus.iBadVAddr;
  end
  assign bad_val = badvaddr_q;
`else
  assign bad_val = '0;
`endif
  assign ip8       = 8'({timer_irq, bus.iPendingInterrupt}) | {6'b0, sw_q};
  assign cause_val = DATA_W'({bd_q, 15'b0, ip8, 1'b0, exc_q, 2'b0});
  // register map shared by mfc0 and the debug display port
  always_comb begin
    for (int i = 0; i < 32; i++) cp0_map[i] = '0;
    cp0_map[REG_BADVADDR] = bad_val;
    cp0_map[REG_COUNT]    = count;
    cp0_map[REG_COMPARE]  = compare;
    cp0_map[REG_SR]       = sr_q;
    cp0_map[REG_CAUSE]    = cause_val;
    cp0_map[REG_EPC]      = epc_q;
  end
  assign bus.oReadData      = cp0_map[bus.iReadRegister];
  assign bus.oRegDisp       = cp0_map[bus.iRegDispSelect];
  assign bus.oEretTarget    = epc_q;
  assign bus.oInterruptMask = sr_q[SR_IE] ? ip8[IRQ_W-1:0] & sr_q[SR_IM_LO +: IRQ_W] : '0;
  assign bus.oIntRequest    = |bus.oInterruptMask && !sr_q[SR_EL];
  assign bus.oUserMode      = sr_q[SR_UM];
  assign bus.oExcLevel      = sr_q[SR_EL];
endmodule
